// File: rtl/spi_host.sv
// spi_host: SPI mode-0 host streaming valid/ready words with CS framing.
// Ports:
//   sys_clock_i, sys_reset_i      clock, asynchronous active-high reset
//   tx_data_i, tx_last_i          word to send (MSB first), release CS after it
//   tx_valid_i, tx_ready_o        word handshake; accept when both are 1
//   rx_data_o, rx_valid_o         received word and its one-cycle strobe
//   busy_o                        1 whenever not idle
//   spi_cs_no, spi_sck_o          chip select (active low), serial clock
//   spi_sd_o, spi_sd_i            serial data out / in
//   spi_stall_i                   asynchronous peripheral backpressure
module spi_host #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sys_clock_i,
    input  logic                  sys_reset_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_last_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  spi_cs_no,
    output logic                  spi_sck_o,
    output logic                  spi_sd_o,
    input  logic                  spi_sd_i,
    input  logic                  spi_stall_i
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int EW = $clog2(2 * DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, NEXT, HOLD, GAP} state_t;
    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic [EW-1:0]         edges;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
    logic [1:0]            sync;
    logic                  last_q, stall_s, tick, accept, done;
    assign stall_s    = sync[1];
    assign tick       = cnt == CW'(CLK_DIV - 1);
    assign tx_ready_o = (state == IDLE || state == NEXT) && !stall_s;
    assign accept     = tx_valid_i && tx_ready_o;
    assign done       = state == SHIFT && tick && edges == EW'(2 * DATA_WIDTH - 1);
    assign busy_o     = state != IDLE;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, NEXT: if (accept) state_n = LEAD;
            LEAD:       if (tick) state_n = SHIFT;
            SHIFT:      if (done) state_n = last_q ? HOLD : NEXT;
            HOLD:       if (tick) state_n = GAP;
            GAP:        if (tick) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end
    // Synchronizer resets to "stalled" so nothing is accepted until the pin is seen low.
    always_ff @(posedge sys_clock_i or posedge sys_reset_i)
        if (sys_reset_i) sync <= 2'b11;
        else             sync <= {sync[0], spi_stall_i};
    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            state      <= IDLE;
            cnt        <= '0;
            edges      <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            last_q     <= 1'b0;
            spi_cs_no  <= 1'b1;
            spi_sck_o  <= 1'b0;
            spi_sd_o   <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= (state_n != state || tick) ? '0 : cnt + 1'b1;
            edges      <= state != SHIFT ? '0 : tick ? edges + 1'b1 : edges;
            rx_valid_o <= done;
            if (done) rx_data_o <= rx_sr;
            if (accept) begin
                tx_sr     <= tx_data_i;
                last_q    <= tx_last_i;
                spi_cs_no <= 1'b0;
                spi_sd_o  <= tx_data_i[DATA_WIDTH-1];
            end
            // SCK low before a tick means this tick is a rising edge.
            if (state == SHIFT && tick) begin
                spi_sck_o <= !spi_sck_o;
                if (!spi_sck_o) rx_sr <= {rx_sr[DATA_WIDTH-2:0], spi_sd_i};
                else if (!done) begin
                    spi_sd_o <= tx_sr[DATA_WIDTH-2];
                    tx_sr    <= tx_sr << 1;
                end
            end
            if (state == HOLD && tick) spi_cs_no <= 1'b1;
        end
    end
endmodule
